// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - parametrised event counter bank with snapshot shadow bank and read port
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   event_i         per-counter increment request
//   enable_i        global run; gates events and window counting
//   clear_i         synchronous clear of live counters, overflow flags, window
//   snap_i          manual snapshot request
//   window_len_i    auto-snapshot period in enabled cycles (0 = off)
//   rd_req_i/rd_sel_i               read request and snapshot index
//   rd_valid_o/rd_data_o/rd_ovf_o   registered read response
//   snap_valid_o/snap_seq_o         snapshot pulse and sequence number
//   ovf_o           live sticky overflow flags

module perf_counter_bank #(
    parameter int NUM_CNT   = 8,
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 1,
    parameter int WIN_WIDTH = 16,
    // derived from NUM_CNT; not meant to be overridden
    parameter int SEL_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CNT-1:0]   event_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 snap_i,
    input  logic [WIN_WIDTH-1:0] window_len_i,
    input  logic                 rd_req_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    output logic                 rd_valid_o,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic                 rd_ovf_o,
    output logic                 snap_valid_o,
    output logic [7:0]           snap_seq_o,
    output logic [NUM_CNT-1:0]   ovf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt      [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap     [NUM_CNT];
    logic [NUM_CNT-1:0]   snap_ovf;
    logic [WIN_WIDTH-1:0] win;

    logic                 win_expire;
    logic                 snap_trig;
    logic [CNT_WIDTH-1:0] rd_mux_data;
    logic                 rd_mux_ovf;

    // Clear outranks expiry, so a clearing cycle never produces an auto-snapshot.
    // The >= lets a window shortened below the current count expire at once.
    assign win_expire = !clear_i && enable_i && (window_len_i != '0) &&
                        (win >= window_len_i - WIN_ONE);
    assign snap_trig  = snap_i || win_expire;

    // Live counters and sticky overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
            ovf_o <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clear_i) begin
                    cnt[i]   <= '0;
                    ovf_o[i] <= 1'b0;
                end else if (win_expire) begin
                    // the expiring cycle's own event belongs to the new window
                    cnt[i]   <= event_i[i] ? CNT_ONE : '0;
                    ovf_o[i] <= 1'b0;
                end else if (enable_i && event_i[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        cnt[i]   <= (SATURATE != 0) ? CNT_MAX : '0;
                        ovf_o[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Window cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (clear_i || (window_len_i == '0) || win_expire) begin
            win <= '0;
        end else if (enable_i) begin
            win <= win + WIN_ONE;
        end
    end

    // Snapshot shadow bank; captures pre-update live values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap[i] <= '0;
            end
            snap_ovf     <= '0;
            snap_seq_o   <= '0;
            snap_valid_o <= 1'b0;
        end else begin
            snap_valid_o <= snap_trig;
            if (snap_trig) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    snap[i] <= cnt[i];
                end
                snap_ovf   <= ovf_o;
                snap_seq_o <= snap_seq_o + 8'd1;
            end
        end
    end

    // Read select; indices past NUM_CNT match nothing and return zero
    always_comb begin
        rd_mux_data = '0;
        rd_mux_ovf  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_mux_data = snap[i];
                rd_mux_ovf  = snap_ovf[i];
            end
        end
    end

    // Registered read port; data holds between requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_ovf_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= rd_mux_data;
                rd_ovf_o  <= rd_mux_ovf;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank (saturating and wrapping instances)

module tb_perf_counter_bank;

    localparam int N  = 6;
    localparam int W  = 4;
    localparam int WW = 8;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  ev = '0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic          snap = 1'b0;
    logic [WW-1:0] wl = '0;
    logic          rd_req = 1'b0;
    logic [2:0]    sel = '0;

    logic          rd_valid  [2];
    logic [W-1:0]  rd_data   [2];
    logic          rd_ovf    [2];
    logic          snap_valid[2];
    logic [7:0]    snap_seq  [2];
    logic [N-1:0]  ovf       [2];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: index 0 = saturating, 1 = wrapping
    int mcnt [2][N];
    bit movf [2][N];
    int msnap[2][N];
    bit msovf[2][N];
    int mrd  [2];
    bit mrovf[2];
    int mwin, mseq;
    bit msv, mrv;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(W), .SATURATE(1), .WIN_WIDTH(WW)) dut_sat (
        .clk(clk), .rst_n(rst_n), .event_i(ev), .enable_i(en), .clear_i(clear),
        .snap_i(snap), .window_len_i(wl), .rd_req_i(rd_req), .rd_sel_i(sel),
        .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]), .rd_ovf_o(rd_ovf[0]),
        .snap_valid_o(snap_valid[0]), .snap_seq_o(snap_seq[0]), .ovf_o(ovf[0]));

    perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(W), .SATURATE(0), .WIN_WIDTH(WW)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .event_i(ev), .enable_i(en), .clear_i(clear),
        .snap_i(snap), .window_len_i(wl), .rd_req_i(rd_req), .rd_sel_i(sel),
        .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]), .rd_ovf_o(rd_ovf[1]),
        .snap_valid_o(snap_valid[1]), .snap_seq_o(snap_seq[1]), .ovf_o(ovf[1]));

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                mcnt[m][i] = 0; movf[m][i] = 0; msnap[m][i] = 0; msovf[m][i] = 0;
            end
            mrd[m] = 0; mrovf[m] = 0;
        end
        mwin = 0; mseq = 0; msv = 0; mrv = 0;
    endfunction

    function automatic void model_step();
        bit expire, trig;
        expire = !clear && en && (wl != 0) && (mwin >= int'(wl) - 1);
        trig   = snap || expire;
        for (int m = 0; m < 2; m++) begin
            if (rd_req) begin
                mrd[m]   = (sel < N) ? msnap[m][sel] : 0;
                mrovf[m] = (sel < N) ? msovf[m][sel] : 0;
            end
            if (trig) begin
                for (int i = 0; i < N; i++) begin
                    msnap[m][i] = mcnt[m][i];
                    msovf[m][i] = movf[m][i];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (clear) begin
                    mcnt[m][i] = 0; movf[m][i] = 0;
                end else if (expire) begin
                    mcnt[m][i] = ev[i] ? 1 : 0; movf[m][i] = 0;
                end else if (en && ev[i]) begin
                    if (mcnt[m][i] == MAXV) begin
                        mcnt[m][i] = (m == 0) ? MAXV : 0;
                        movf[m][i] = 1;
                    end else begin
                        mcnt[m][i] = mcnt[m][i] + 1;
                    end
                end
            end
        end
        if (clear || wl == 0 || expire) mwin = 0;
        else if (en) mwin = mwin + 1;
        if (trig) mseq = (mseq + 1) % 256;
        msv = trig;
        mrv = rd_req;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ev = '0; en = 1'b0; clear = 1'b0; snap = 1'b0; wl = '0; rd_req = 1'b0; sel = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (rd_valid[m] !== 1'b0 || rd_data[m] !== '0 || rd_ovf[m] !== 1'b0 ||
                snap_valid[m] !== 1'b0 || snap_seq[m] !== 8'd0 || ovf[m] !== '0) begin
                n_errors++;
                $display("FAIL reset dut%0d: valid=%b data=%0d rovf=%b sv=%b seq=%0d ovf=%b, required all 0",
                         m, rd_valid[m], rd_data[m], rd_ovf[m], snap_valid[m], snap_seq[m], ovf[m]);
            end
        end
    endtask

    task automatic test_basic();
        en = 1'b1; ev = 6'b000001;
        repeat (5) tick();
        ev = '0; snap = 1'b1;
        tick();
        snap = 1'b0;
        n_checks++;
        if (snap_valid[0] !== 1'b1 || snap_seq[0] !== 8'd1) begin
            n_errors++;
            $display("FAIL basic_snap: snap_valid=%b seq=%0d, required 1 and 1", snap_valid[0], snap_seq[0]);
        end
        rd_req = 1'b1; sel = 3'd0;
        tick();
        rd_req = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (rd_valid[m] !== 1'b1 || rd_data[m] !== 4'd5 || ovf[m] !== '0 || snap_valid[m] !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_read dut%0d: valid=%b data=%0d ovf=%b sv=%b, required 1 5 0 0",
                         m, rd_valid[m], rd_data[m], ovf[m], snap_valid[m]);
            end
        end
        tick();
        n_checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 4'd5) begin
            n_errors++;
            $display("FAIL basic_hold: valid=%b data=%0d, required 0 5", rd_valid[0], rd_data[0]);
        end
    endtask

    task automatic test_overflow();
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; ev = 6'b000010;
        repeat (17) tick();
        ev = '0;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (ovf[m][1] !== 1'b1) begin
                n_errors++;
                $display("FAIL ovf_flag dut%0d: ovf=%b, required bit1 set", m, ovf[m]);
            end
        end
        snap = 1'b1; tick(); snap = 1'b0;
        rd_req = 1'b1; sel = 3'd1; tick(); rd_req = 1'b0;
        n_checks++;
        if (rd_data[0] !== 4'd15 || rd_ovf[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_saturate: data=%0d rovf=%b, required 15 1", rd_data[0], rd_ovf[0]);
        end
        n_checks++;
        if (rd_data[1] !== 4'd1 || rd_ovf[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_wrap: data=%0d rovf=%b, required 1 1", rd_data[1], rd_ovf[1]);
        end
    endtask

    task automatic test_window();
        int seq0, npulse;
        en = 1'b1; ev = 6'b000100; wl = 8'd4; rd_req = 1'b1; sel = 3'd2;
        clear = 1'b1; tick(); clear = 1'b0;
        seq0 = snap_seq[0];
        npulse = 0;
        for (int t = 1; t <= 13; t++) begin
            tick();
            // windows after the first hold a full 4 events; read lands one cycle after the snapshot
            if (npulse >= 2 && t == 4 * npulse + 1) begin
                n_checks++;
                if (rd_data[0] !== 4'd4 || rd_data[1] !== 4'd4) begin
                    n_errors++;
                    $display("FAIL window_value t=%0d: data=%0d/%0d, required 4", t, rd_data[0], rd_data[1]);
                end
            end
            if (snap_valid[0]) begin
                npulse++;
                n_checks++;
                if (t != 4 * npulse || snap_seq[0] !== 8'((seq0 + npulse) % 256)) begin
                    n_errors++;
                    $display("FAIL window_pulse: cycle=%0d seq=%0d, required cycle %0d seq %0d",
                             t, snap_seq[0], 4 * npulse, (seq0 + npulse) % 256);
                end
            end
        end
        n_checks++;
        if (npulse != 3) begin
            n_errors++;
            $display("FAIL window_count: pulses=%0d, required 3", npulse);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_snap_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; ev = 6'b000001;
        repeat (7) tick();
        ev = '0; snap = 1'b1; clear = 1'b1; tick(); snap = 1'b0; clear = 1'b0;
        rd_req = 1'b1; sel = 3'd0; tick(); rd_req = 1'b0;
        n_checks++;
        if (rd_data[0] !== 4'd7 || rd_data[1] !== 4'd7) begin
            n_errors++;
            $display("FAIL snap_clear_pre: data=%0d/%0d, required 7", rd_data[0], rd_data[1]);
        end
        snap = 1'b1; tick(); snap = 1'b0;
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        n_checks++;
        if (rd_data[0] !== 4'd0 || rd_valid[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL snap_clear_post: data=%0d valid=%b, required 0 1", rd_data[0], rd_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; ev = 6'b000001;
        repeat (3) tick();
        ev = '0; snap = 1'b1; tick(); snap = 1'b0;
        rd_req = 1'b1; sel = 3'd0; tick();
        n_checks++;
        if (rd_data[0] !== 4'd3) begin
            n_errors++;
            $display("FAIL b2b_first: data=%0d, required 3", rd_data[0]);
        end
        sel = 3'd6; tick();
        n_checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 4'd0 || rd_ovf[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL oob_read: valid=%b data=%0d rovf=%b, required 1 0 0", rd_valid[0], rd_data[0], rd_ovf[0]);
        end
        rd_req = 1'b0; ev = 6'b000001;
        repeat (2) tick();
        ev = '0; snap = 1'b1; rd_req = 1'b1; sel = 3'd0; tick(); snap = 1'b0;
        n_checks++;
        if (rd_data[0] !== 4'd3 || rd_data[1] !== 4'd3) begin
            n_errors++;
            $display("FAIL same_edge_read: data=%0d/%0d, required 3", rd_data[0], rd_data[1]);
        end
        tick(); rd_req = 1'b0;
        n_checks++;
        if (rd_data[0] !== 4'd5) begin
            n_errors++;
            $display("FAIL next_read: data=%0d, required 5", rd_data[0]);
        end
    endtask

    task automatic test_reset_midwindow();
        int k;
        en = 1'b1; ev = 6'b001000; wl = 8'd4; rd_req = 1'b1; sel = 3'd0;
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (rd_valid[m] !== 1'b0 || rd_data[m] !== '0 || rd_ovf[m] !== 1'b0 ||
                snap_valid[m] !== 1'b0 || snap_seq[m] !== 8'd0 || ovf[m] !== '0) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: valid=%b data=%0d rovf=%b sv=%b seq=%0d ovf=%b, required all 0",
                         m, rd_valid[m], rd_data[m], rd_ovf[m], snap_valid[m], snap_seq[m], ovf[m]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; rd_req = 1'b0;
        k = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (snap_valid[0] && k == 0) k = t;
        end
        n_checks++;
        if (k != 4) begin
            n_errors++;
            $display("FAIL reset_first_expiry: cycle=%0d, required 4", k);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ovf;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) wl = WW'($urandom_range(0, 6));
            en     = ($urandom % 8) != 0;
            ev     = N'($urandom);
            clear  = ($urandom % 32) == 0;
            snap   = ($urandom % 8) == 0;
            rd_req = $urandom % 2;
            sel    = 3'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) exp_ovf[i] = movf[m][i];
                n_checks++;
                if (rd_valid[m] !== mrv || rd_data[m] !== W'(mrd[m]) || rd_ovf[m] !== mrovf[m] ||
                    snap_valid[m] !== msv || snap_seq[m] !== 8'(mseq) || ovf[m] !== exp_ovf) begin
                    n_errors++;
                    $display("FAIL random c=%0d dut%0d: got v=%b d=%0d o=%b sv=%b seq=%0d ovf=%b, required v=%b d=%0d o=%b sv=%b seq=%0d ovf=%b",
                             c, m, rd_valid[m], rd_data[m], rd_ovf[m], snap_valid[m], snap_seq[m], ovf[m],
                             mrv, mrd[m], mrovf[m], msv, mseq, exp_ovf);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_window();
        test_snap_clear();
        test_back_to_back();
        test_reset_midwindow();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
